// File: rtl/send_wiener_para.sv
// send_wiener_para: streams one Wiener-coefficient frame to a downstream sink.
// A frame is a header word, an endpoint address word, then N_WORDS
// coefficients read from an external RAM with one cycle of read latency.
// Every word leaves byte-swapped on a valid/ready handshake.
module send_wiener_para #(
    parameter logic [15:0] HEADER   = 16'hC7E5,
    parameter int          N_WORDS  = 256,
    parameter logic [7:0]  ADDR_LSB = 8'h00
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  ep_addr,
    input  logic [15:0] rd_ram_data,
    input  logic        tx_ready,
    output logic        rd_ram_en,
    output logic [7:0]  rd_ram_addr,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HEAD  = 3'd1,
        ADDR  = 3'd2,
        FETCH = 3'd3,
        LOAD  = 3'd4,
        SEND  = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Index of the final coefficient; word_cnt never advances past it.
    localparam logic [7:0] LAST_CNT = 8'(N_WORDS - 1);

    state_t     state;
    logic [7:0] word_cnt;
    logic [7:0] ep_addr_q;
    logic       xfer;

    // A word moves only when both sides agree in the same cycle.
    assign xfer = tx_valid & tx_ready;

    // The sink expects the low byte first on the wire.
    function automatic logic [15:0] swap_bytes(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    // Frame sequencer: all outputs are registered and owned by this block.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx_data     <= 16'h0000;
            tx_valid    <= 1'b0;
            rd_ram_en   <= 1'b0;
            rd_ram_addr <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
            word_cnt    <= 8'h00;
            ep_addr_q   <= 8'h00;
        end else if (abort && (state != IDLE)) begin
            // Abort wins over any handshake in the same cycle, so a word
            // accepted together with abort is treated as never sent.
            state     <= IDLE;
            tx_valid  <= 1'b0;
            rd_ram_en <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            word_cnt  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Endpoint address is frozen for the whole frame.
                        ep_addr_q <= ep_addr;
                        word_cnt  <= 8'h00;
                        tx_data   <= swap_bytes(HEADER);
                        tx_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= HEAD;
                    end
                end
                HEAD: begin
                    if (xfer) begin
                        tx_data <= swap_bytes({ep_addr_q, ADDR_LSB});
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (xfer) begin
                        tx_valid    <= 1'b0;
                        rd_ram_en   <= 1'b1;
                        rd_ram_addr <= word_cnt;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    // Read strobe lasts exactly this one cycle.
                    rd_ram_en <= 1'b0;
                    state     <= LOAD;
                end
                LOAD: begin
                    // RAM data arrives one cycle after the strobe.
                    tx_data  <= swap_bytes(rd_ram_data);
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        tx_valid <= 1'b0;
                        if (word_cnt == LAST_CNT) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            word_cnt    <= word_cnt + 8'd1;
                            rd_ram_en   <= 1'b1;
                            rd_ram_addr <= word_cnt + 8'd1;
                            state       <= FETCH;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_send_wiener_para.sv
// Directed bench for send_wiener_para: full frames with steady and random
// backpressure, held start, abort mid-frame, asynchronous reset mid-frame,
// and a receiver-side rebuild of the RAM image from the stream.
`timescale 1ns/1ps
module tb_send_wiener_para;

    localparam int N = 256;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic        start  = 1'b0;
    logic        abort  = 1'b0;
    logic [7:0]  ep_addr = 8'h00;
    logic [15:0] rd_ram_data = 16'h0000;
    logic        tx_ready = 1'b1;
    logic        rd_ram_en;
    logic [7:0]  rd_ram_addr;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;

    logic [15:0] ram    [0:N-1];
    logic [15:0] rx_mem [0:N-1];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] rx_q[$];
    int          xc_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_xfer_cyc = 0;
    int          stab_err = 0;
    bit          stab_on  = 1'b1;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_data  = 16'h0000;

    always #5 clk_in = ~clk_in;

    send_wiener_para dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .ep_addr     (ep_addr),
        .rd_ram_data (rd_ram_data),
        .tx_ready    (tx_ready),
        .rd_ram_en   (rd_ram_en),
        .rd_ram_addr (rd_ram_addr),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .busy        (busy),
        .done        (done)
    );

    // Coefficient RAM with one cycle of read latency, plus a cycle counter.
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (rd_ram_en) rd_ram_data <= ram[rd_ram_addr];
    end

    // Stream monitor: records accepted words, done pulses and hold violations.
    always @(negedge clk_in) begin
        if (stab_on && prev_valid && !prev_ready &&
            (tx_valid !== 1'b1 || tx_data !== prev_data))
            stab_err <= stab_err + 1;
        if (tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
            xc_q.push_back(cyc);
            last_xfer_cyc <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        prev_valid <= tx_valid;
        prev_ready <= tx_ready;
        prev_data  <= tx_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller is at posedge+1; the DUT samples start on the next edge.
    task automatic start_frame(input logic [7:0] ep);
        rx_q.delete();
        xc_q.delete();
        ep_addr = ep;
        start   = 1'b1;
        @(posedge clk_in);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit rnd, input int budget);
        int d0;
        bit ok;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_in);
            #1;
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        tx_ready = 1'b1;
        check_eq({tag, " done seen"}, 32'(ok), 32'd1);
    endtask

    // Receiver model: checks framing, unswaps the payload into rx_mem and
    // compares the rebuilt image with the RAM contents.
    task automatic check_frame(input string tag, input logic [15:0] exp_addr_word);
        int err;
        logic [15:0] w;
        check_eq({tag, " word count"}, 32'(rx_q.size()), 32'(N + 2));
        if (rx_q.size() == N + 2) begin
            check_eq({tag, " header"}, 32'(rx_q[0]), 32'h0000E5C7);
            check_eq({tag, " addr word"}, 32'(rx_q[1]), 32'(exp_addr_word));
            check_eq({tag, " coef0"}, 32'(rx_q[2]), 32'h00000000);
            check_eq({tag, " coef1"}, 32'(rx_q[3]), 32'h00000100);
            check_eq({tag, " coef255"}, 32'(rx_q[N + 1]), 32'h0000FF00);
            err = 0;
            for (int i = 0; i < N; i++) begin
                w = rx_q[i + 2];
                rx_mem[i] = {w[7:0], w[15:8]};
                if (rx_mem[i] !== ram[i]) err++;
            end
            check_eq({tag, " rx ram errors"}, 32'(err), 32'd0);
        end
    endtask

    initial begin
        int bad;
        int d0;
        bit found;

        for (int i = 0; i < N; i++) ram[i] = 16'(i);

        // Reset state, observed before any clock edge.
        #1 reset = 1'b1;
        #1;
        check_eq("rst tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst tx_data", 32'(tx_data), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        check_eq("rst rd_ram_en", 32'(rd_ram_en), 32'd0);
        check_eq("rst rd_ram_addr", 32'(rd_ram_addr), 32'd0);
        repeat (3) @(posedge clk_in);
        #1 reset = 1'b0;
        @(posedge clk_in);
        #1;

        // Frame with tx_ready held high.
        start_frame(8'h3C);
        check_eq("f1 busy after start", 32'(busy), 32'd1);
        check_eq("f1 first word", 32'(tx_data), 32'h0000E5C7);
        wait_done("f1", 1'b0, 4000);
        check_frame("f1", 16'h003C);
        check_eq("f1 done lag", 32'(done_cyc - last_xfer_cyc), 32'd1);
        check_eq("f1 hdr to addr", 32'(xc_q[1] - xc_q[0]), 32'd1);
        bad = 0;
        for (int i = 2; i < N + 1; i++)
            if (xc_q[i + 1] - xc_q[i] != 3) bad++;
        check_eq("f1 coef period", 32'(bad), 32'd0);
        check_eq("f1 busy idle", 32'(busy), 32'd0);

        // Random backpressure; ep_addr changes after start and must not leak.
        start_frame(8'h3C);
        ep_addr = 8'h55;
        wait_done("f2", 1'b1, 8000);
        check_frame("f2", 16'h003C);
        check_eq("f2 hold stable", 32'(stab_err), 32'd0);

        // start held through the frame, including the DONE cycle.
        @(posedge clk_in);
        #1;
        rx_q.delete();
        xc_q.delete();
        ep_addr = 8'h3C;
        start   = 1'b1;
        d0 = done_cnt;
        wait_done("f3", 1'b0, 4000);
        start = 1'b0;
        repeat (10) @(posedge clk_in);
        #1;
        check_frame("f3", 16'h003C);
        check_eq("f3 one done", 32'(done_cnt - d0), 32'd1);
        check_eq("f3 no restart", 32'(busy), 32'd0);

        // Abort coinciding with the transfer of coefficient 100.
        start_frame(8'h3C);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_in);
            #1;
            if (tx_valid && tx_data == 16'h6400) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("ab coef100 reached", 32'(found), 32'd1);
        abort = 1'b1;
        d0 = done_cnt;
        @(posedge clk_in);
        #1 abort = 1'b0;
        check_eq("ab tx_valid", 32'(tx_valid), 32'd0);
        check_eq("ab busy", 32'(busy), 32'd0);
        check_eq("ab rd_ram_en", 32'(rd_ram_en), 32'd0);
        check_eq("ab done", 32'(done), 32'd0);
        repeat (5) @(posedge clk_in);
        #1;
        check_eq("ab no done", 32'(done_cnt - d0), 32'd0);
        start_frame(8'h3C);
        wait_done("ab restart", 1'b0, 4000);
        check_frame("ab restart", 16'h003C);

        // Asynchronous reset while coefficient 10 is held in SEND.
        stab_on = 1'b0;
        start_frame(8'h3C);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk_in);
            #1;
            if (tx_valid && tx_data == 16'h0A00) begin
                found = 1'b1;
                break;
            end
        end
        tx_ready = 1'b0;
        check_eq("rs coef10 reached", 32'(found), 32'd1);
        check_eq("rs addr before", 32'(rd_ram_addr), 32'd10);
        #2 reset = 1'b1;
        #1;
        check_eq("rs tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rs tx_data", 32'(tx_data), 32'd0);
        check_eq("rs busy", 32'(busy), 32'd0);
        check_eq("rs done", 32'(done), 32'd0);
        check_eq("rs rd_ram_en", 32'(rd_ram_en), 32'd0);
        check_eq("rs rd_ram_addr", 32'(rd_ram_addr), 32'd0);
        @(posedge clk_in);
        #1 reset = 1'b0;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 stab_on = 1'b1;
        start_frame(8'h3C);
        wait_done("rs restart", 1'b0, 4000);
        check_frame("rs restart", 16'h003C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
